// File: rtl/shift_unit.sv
// Multi-cycle shift/rotate unit (SLL/SRL/SRA/ROR/ROL) with a start/done handshake.
// Define SHIFT_BARREL_EN to compute the result in one cycle instead of one bit per cycle.
module shift_unit #(
    parameter int WIDTH = 32,
    parameter int AMT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in_value,
    input  logic [AMT_W-1:0] in_amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [2:0] OP_SLL = 3'b001;
    localparam logic [2:0] OP_SRL = 3'b010;
    localparam logic [2:0] OP_SRA = 3'b011;
    localparam logic [2:0] OP_ROR = 3'b100;
    localparam logic [2:0] OP_ROL = 3'b101;

    logic [1:0]       state;
    logic [WIDTH-1:0] sreg;
    logic [2:0]       op_q;
    logic [AMT_W-1:0] cnt;

    // Moves the register one bit position; unknown codes pass through unchanged.
    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] v, input logic [2:0] code);
        logic [WIDTH-1:0] r;
        r = v;
        case (code)
            OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
            OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
            OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
            OP_ROR:  r = {v[0], v[WIDTH-1:1]};
            OP_ROL:  r = {v[WIDTH-2:0], v[WIDTH-1]};
            default: r = v;
        endcase
        return r;
    endfunction

`ifdef SHIFT_BARREL_EN
    function automatic logic [WIDTH-1:0] barrel(input logic [WIDTH-1:0] v, input logic [2:0] code,
                                                input logic [AMT_W-1:0] amt);
        logic [2*WIDTH-1:0] d;
        logic [WIDTH-1:0]   r;
        d = '0;
        r = v;
        case (code)
            OP_SLL:  r = v << amt;
            OP_SRL:  r = v >> amt;
            OP_SRA:  r = WIDTH'($signed(v) >>> amt);
            OP_ROR: begin
                d = {v, v} >> amt;
                r = d[WIDTH-1:0];
            end
            OP_ROL: begin
                d = {v, v} << amt;
                r = d[2*WIDTH-1:WIDTH];
            end
            default: r = v;
        endcase
        return r;
    endfunction
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            sreg  <= '0;
            op_q  <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_q <= op;
`ifdef SHIFT_BARREL_EN
                        sreg  <= barrel(in_value, op, in_amount);
                        cnt   <= '0;
                        state <= DONE;
`else
                        sreg  <= in_value;
                        cnt   <= in_amount;
                        state <= (in_amount != '0) ? SHIFT : DONE;
`endif
                    end
                end
                SHIFT: begin
                    sreg <= step(sreg, op_q);
                    cnt  <= cnt - 1'b1;
                    if (cnt == AMT_W'(1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign out  = sreg;

endmodule

// File: tb/tb_shift_unit.sv
// Self-checking bench for shift_unit: directed cases plus randomized traffic against
// a cycle-accurate behavioural model built from the result and latency rules.
module tb_shift_unit;

`ifdef SHIFT_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] in_value;
    logic [4:0]  in_amount;
    logic        busy;
    logic        done;
    logic [31:0] out;

    int checks;
    int failures;

    shift_unit #(.WIDTH(32), .AMT_W(5)) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .op(op),
        .in_value(in_value),
        .in_amount(in_amount),
        .busy(busy),
        .done(done),
        .out(out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference result: operand shifted/rotated by n positions.
    function automatic logic [31:0] ref_shift(input logic [31:0] v, input logic [2:0] code, input int n);
        logic [63:0] d;
        logic [31:0] r;
        d = {v, v};
        case (code)
            3'b001:  r = v << n;
            3'b010:  r = v >> n;
            3'b011:  r = $signed(v) >>> n;
            3'b100: begin
                d = d >> n;
                r = d[31:0];
            end
            3'b101: begin
                d = d << n;
                r = d[63:32];
            end
            default: r = v;
        endcase
        return r;
    endfunction

    function automatic int latency(input int amt);
        return BARREL ? 1 : amt + 1;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model: tracks one accepted operation by absolute cycle numbers.
    int          cyc = 0;
    bit          m_valid = 1'b0;
    bit          m_active = 1'b0;
    int          m_c0 = 0;
    int          m_done_cyc = 0;
    logic [31:0] m_val = '0;
    logic [2:0]  m_op = '0;
    int          m_amt = 0;
    logic [31:0] m_hold = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_valid  <= 1'b1;
            m_active <= 1'b0;
            m_hold   <= '0;
        end else if (m_active) begin
            if (cyc == m_done_cyc) begin
                m_active <= 1'b0;
                m_hold   <= ref_shift(m_val, m_op, m_amt);
            end
        end else if (start) begin
            m_active   <= 1'b1;
            m_c0       <= cyc;
            m_val      <= in_value;
            m_op       <= op;
            m_amt      <= int'(in_amount);
            m_done_cyc <= cyc + latency(int'(in_amount));
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    always @(negedge clk) begin
        logic        e_busy;
        logic        e_done;
        logic [31:0] e_out;
        if (m_valid) begin
            if (m_active) begin
                e_busy = 1'b1;
                e_done = (cyc == m_done_cyc);
                e_out  = BARREL ? ref_shift(m_val, m_op, m_amt) : ref_shift(m_val, m_op, cyc - m_c0 - 1);
            end else begin
                e_busy = 1'b0;
                e_done = 1'b0;
                e_out  = m_hold;
            end
            checkOutput("model_busy", {31'b0, busy}, {31'b0, e_busy});
            checkOutput("model_done", {31'b0, done}, {31'b0, e_done});
            checkOutput("model_out", out, e_out);
        end
    end

    // One operation: start in cycle 0, report the cycle done fires and the result then.
    task automatic applyStimulus(input logic [2:0] o, input logic [31:0] v, input logic [4:0] a,
                                 output int done_cyc, output logic [31:0] res);
        @(negedge clk);
        start = 1'b1;
        op = o;
        in_value = v;
        in_amount = a;
        done_cyc = -1;
        res = '0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start = 1'b0;
                op = 3'($urandom);
                in_value = $urandom;
                in_amount = 5'($urandom);
            end
            if (done && done_cyc < 0) begin
                done_cyc = k;
                res = out;
            end
            if (!busy && done_cyc >= 0) break;
        end
    endtask

    initial begin
        int          dc;
        int          done_seen;
        logic [31:0] r;
        checks = 0;
        failures = 0;
        reset = 1'b1;
        start = 1'b0;
        op = '0;
        in_value = '0;
        in_amount = '0;

        checkOutput("pin_rol", ref_shift(32'h8000_0001, 3'b101, 1), 32'h0000_0003);
        checkOutput("pin_ror", ref_shift(32'h8000_0001, 3'b100, 1), 32'hC000_0000);
        checkOutput("pin_sra", ref_shift(32'h8000_0000, 3'b011, 4), 32'hF800_0000);

        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_out", out, 32'h0);
        checkOutput("reset_busy", {31'b0, busy}, 32'h0);
        checkOutput("reset_done", {31'b0, done}, 32'h0);

        applyStimulus(3'b011, 32'h8000_0000, 5'd4, dc, r);
        checkOutput("sra_cycle", dc, latency(4));
        checkOutput("sra_out", r, 32'hF800_0000);

        applyStimulus(3'b101, 32'h8000_0001, 5'd1, dc, r);
        checkOutput("rol_cycle", dc, latency(1));
        checkOutput("rol_out", r, 32'h0000_0003);

        applyStimulus(3'b100, 32'h8000_0001, 5'd1, dc, r);
        checkOutput("ror_out", r, 32'hC000_0000);

        applyStimulus(3'b001, 32'h1234_5678, 5'd0, dc, r);
        checkOutput("sll0_cycle", dc, 1);
        checkOutput("sll0_out", r, 32'h1234_5678);

        applyStimulus(3'b010, 32'hFFFF_FFFF, 5'd31, dc, r);
        checkOutput("srl31_cycle", dc, latency(31));
        checkOutput("srl31_out", r, 32'h0000_0001);

        applyStimulus(3'b111, 32'hDEAD_BEEF, 5'd3, dc, r);
        checkOutput("pass_out", r, 32'hDEAD_BEEF);

        // A start pulse during the operation must be ignored.
        @(negedge clk);
        start = 1'b1; op = 3'b001; in_value = 32'h1; in_amount = 5'd8;
        dc = -1; r = '0; done_seen = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            start = (k == 3);
            if (k == 3) begin
                op = 3'b010; in_value = 32'h0000_FFFF; in_amount = 5'd1;
            end
            if (done) begin
                done_seen++;
                if (dc < 0) begin
                    dc = k;
                    r = out;
                end
            end
        end
        checkOutput("busy_start_cycle", dc, BARREL ? 1 : 9);
        checkOutput("busy_start_out", r, 32'h0000_0100);
        checkOutput("busy_start_pulses", done_seen, 1);

        // Reset in the middle of an operation aborts it without a done pulse.
        @(negedge clk);
        start = 1'b1; op = 3'b001; in_value = 32'h1; in_amount = 5'd10;
        done_seen = 0;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (done && !BARREL) done_seen++;
            if (k == 4) reset = 1'b1;
            if (k == 5) begin
                checkOutput("abort_out", out, 32'h0);
                checkOutput("abort_busy", {31'b0, busy}, 32'h0);
                reset = 1'b0;
            end
        end
        checkOutput("abort_no_done", done_seen, 0);
        applyStimulus(3'b001, 32'h1, 5'd2, dc, r);
        checkOutput("after_abort_cycle", dc, latency(2));
        checkOutput("after_abort_out", r, 32'h4);

        // Random traffic: the per-cycle model comparison does the checking.
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) == 0);
            op = 3'($urandom);
            in_value = $urandom;
            case ($urandom_range(0, 5))
                0:       in_amount = 5'd0;
                1:       in_amount = 5'd31;
                default: in_amount = 5'($urandom);
            endcase
            reset = ($urandom_range(0, 150) == 0);
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        repeat (40) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/shift_unit.md
# shift_unit

Multi-cycle shift register unit for the multicycle MIPS datapath. It sits directly downstream of the shift-source selection stage, which supplies a 32-bit operand and a 5-bit shift amount. It performs SLL/SRL/SRA/ROR/ROL under a start/done handshake with the control unit, and holds the result for write-back to the register file. The default build shifts one bit per cycle; the `SHIFT_BARREL_EN` build produces the result in a single cycle.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width.
- `AMT_W`, 5: shift-amount width; must satisfy 2^AMT_W = WIDTH.

Ports:
- `clk` input 1: sole clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: request a shift; sampled only in IDLE.
- `op` input 3: operation code.
  - 001 SLL, 010 SRL, 011 SRA, 100 ROR, 101 ROL.
  - All other codes are pass-through (result = operand).
- `in_value` input WIDTH: operand from the shift-source stage.
- `in_amount` input AMT_W: shift amount, unsigned.
- `busy` output 1: high whenever state ≠ IDLE.
- `done` output 1: one-cycle pulse when the result is valid.
- `out` output WIDTH: the shift register contents, i.e. the result once `done` fires.

## Operation
- Internal state:
  - `sreg` (WIDTH bits).
  - Latched `op_q` (3 bits).
  - Down-counter `cnt` (AMT_W bits).
  - FSM with three states: IDLE, SHIFT, DONE.
- IDLE:
  - `start` = 1 → `sreg` ← `in_value`, `op_q` ← `op`, `cnt` ← `in_amount`.
  - Next state is SHIFT if `in_amount` ≠ 0, otherwise DONE.
  - `start` = 0 → remain in IDLE; `sreg` holds its value.
- SHIFT: each cycle `sreg` moves one bit position per `op_q` and `cnt` decrements.
  - SLL: zero fill at the LSB.
  - SRL: zero fill at the MSB.
  - SRA: replicate the MSB.
  - ROR: LSB → MSB.
  - ROL: MSB → LSB.
  - Pass-through codes leave `sreg` unchanged but still consume the count.
  - When `cnt` = 1 at the edge, the next state is DONE.
- DONE: `done` = 1 for exactly one cycle; the next state is IDLE unconditionally.
- `start` is ignored in SHIFT and DONE; no queuing.
- `in_value`, `in_amount` and `op` need only be valid in the cycle `start` is sampled; later changes have no effect.
- `out` = `sreg` at all times.
  - It is stable from DONE until the next accepted `start`.
  - During SHIFT it shows intermediate values; consumers must qualify it with `done` or `!busy`.
- Shift amounts are taken modulo WIDTH by construction; rotates by 0 return the operand unchanged.

## Timing
- Reset values: state IDLE, `sreg` = 0, `cnt` = 0, `op_q` = 0. Hence `out` = 0, `busy` = 0, `done` = 0.
- Reset asserted mid-SHIFT or in DONE:
  - The next edge forces the reset values.
  - No `done` pulse is produced for the aborted operation.
- Latency, counted from the cycle `start` is high in IDLE (cycle 0):
  - `done` is high in cycle `in_amount` + 1.
  - `busy` is high in cycles 1 through `in_amount` + 1.
- Amount 0: `done` is high in cycle 1 and `out` = `in_value`.
- Maximum amount 31: `done` is high in cycle 32.
- Back-to-back operation: the earliest next accepted `start` is in the cycle after `done` (IDLE). Throughput is one operation per `in_amount` + 2 cycles.
- Simultaneous `reset` and `start`: reset wins; the operation is not accepted.

## Configuration
- `SHIFT_BARREL_EN` defined:
  - In IDLE with `start`, `sreg` is loaded directly with the fully shifted result (combinational barrel shift by `in_amount`) and the FSM goes straight to DONE.
  - `done` is high in cycle 1 for every amount; the SHIFT state is never entered.
  - `cnt` is unused and stays 0.
- `SHIFT_BARREL_EN` undefined: the serial behaviour described above. The result values are identical in both builds.

## Test plan
- Reset: hold `reset` 2 cycles, then release → `out` = 0x00000000, `busy` = 0, `done` = 0.
- SRA: `in_value` = 0x80000000, `in_amount` = 4, `op` = 011 → `done` in cycle 5 (cycle 1 in barrel build), `out` = 0xF8000000, `busy` high in cycles 1–5.
- ROL and ROR:
  - `in_value` = 0x80000001, amount 1, ROL → `out` = 0x00000003, `done` in cycle 2.
  - Same operand, amount 1, ROR → `out` = 0xC0000000.
- SLL amount 0 and SRL 31:
  - SLL, `in_value` = 0x12345678, amount 0 → `done` in cycle 1, `out` = 0x12345678.
  - SRL, `in_value` = 0xFFFFFFFF, amount 31 → `done` in cycle 32, `out` = 0x00000001.
- Start while busy: SLL 0x1 by 8, and in cycle 3 pulse `start` with SRL 0xFFFF by 1 → the second request is ignored; `done` only in cycle 9, `out` = 0x00000100.
- Reset mid-operation: SLL 0x1 by 10, assert `reset` in cycle 4 → cycle 5 shows `out` = 0, `busy` = 0, and `done` never pulses; a new SLL 0x1 by 2 then yields 0x4 with `done` in cycle 3.
